smc_obv_ctrl_pipe: RTL and testbench
====================================

// Module: smc_obv_ctrl_pipe
// PURPOSE
//  Pipelined, parametrised sliding-mode position controller with disturbance-observer feedforward for the SEA joint loop.
//  Registered successor of the combinational SMC/observer law: configurable width, gains and shifts; sign or boundary-layer switching term.
//  Adds saturating arithmetic with a sticky overflow flag, output clamping and a valid/enable handshake.
//  Sits between trajectory generator / encoder filters and the motor current command.
// PARAMETERS
//  W        32     datapath width, signed two's complement
//  GW       9      gain operand width (unsigned)
//  C        10     sliding-surface slope c
//  K        10     reaching gain k
//  B        25     observer damping gain b
//  XITE     1000   switching amplitude
//  JM       7      observer arithmetic right shift
//  JD       7      output arithmetic right shift
//  BOUNDARY 0      0: sign(s) switching; 1: boundary layer clamp(s>>>PHI_SH, +-XITE)
//  PHI_SH   4      boundary-layer shift (BOUNDARY=1 only)
//  U_MAX    32767  output clamp magnitude; u limited to [-U_MAX, +U_MAX]
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   synchronous reset, active low
//  en        in   1   pipeline advance; 0 freezes every stage, including valid bits
//  in_valid  in   1   input sample qualifier
//  thetad    in   W   desired position
//  dthetad   in   W   desired velocity
//  ddthetad  in   W   desired acceleration
//  theta     in   W   measured position
//  dtheta    in   W   measured velocity
//  dp        in   W   disturbance estimate term
//  ov_clr    in   1   clears ov_sticky
//  u         out  W   control output
//  out_valid out  1   u qualifier, one pulse per accepted sample
//  u_sat     out  1   u was clamped to +-U_MAX (qualified by out_valid)
//  ov_sticky out  1   any internal add/multiply saturated since last clear
// BEHAVIOUR
//  - One clock, one reset. Reset is synchronous, active-low, and overrides en.
//    All pipeline registers, u, out_valid, u_sat and ov_sticky reset to 0.
//  - Fixed 6-cycle latency from in_valid&en to out_valid (counted in en-high cycles). Throughput is 1 sample/cycle with no backpressure.
//  - The valid bit travels with the data; stages holding invalid data still compute but never raise out_valid.
//  - S1: e = thetad-theta; de = dthetad-dtheta; bd = B*dtheta.
//  - S2: ce = C*e; cde = C*de; obv_e = bd-dp; e, de forwarded.
//  - S3: s = ce+de; u1 = cde+ddthetad; obv = obv_e>>>JM.
//    Switching term sw: BOUNDARY=0 gives +XITE if s>=0, else -XITE (s=0 maps to +XITE).
//    BOUNDARY=1 gives clamp(s>>>PHI_SH, -XITE, +XITE).
//  - S4: ks = K*s; u2 = obv+sw; u1 forwarded.
//  - S5: u3 = u1+u2; ks forwarded.
//  - S6: ut = u3+ks; u = clamp(ut>>>JD, +-U_MAX); u_sat = clamp active.
//  - Every add and multiply saturates to [-2^(W-1), 2^(W-1)-1].
//    A saturation event in a valid stage sets ov_sticky the following cycle. Events in invalid stages are ignored.
//  - ov_sticky: set takes priority over a simultaneous ov_clr. Cleared only by ov_clr or reset.
//  - Multipliers treat gains as unsigned GW-bit values. The full product is formed, then saturated to W bits.
//  - Right shifts are arithmetic, floor toward -inf.
//  - u and u_sat hold their value while out_valid=0 and while en=0.
//  - Reset mid-operation discards all in-flight samples; no out_valid is produced for them.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles, en=1, in_valid=1 -> u=0, out_valid=0, ov_sticky=0 throughout.
//  2. thetad=1000, other inputs 0, BOUNDARY=0 -> 6 cycles later out_valid=1, u=789.
//     Same sample with thetad=-1000 -> u=-790.
//  3. Observer path: dthetad=dtheta=128, thetad=theta=0, dp=0 -> obv=25, sw=+1000, u=8.
//  4. BOUNDARY=1, thetad=1000, others 0 -> sw=625, u=786.
//  5. Clamps:
//     - thetad=1048576, others 0 -> u=32767, u_sat=1, ov_sticky=0.
//     - thetad=0x7FFF0000, theta=-0x7FFF0000 -> e saturates, ov_sticky=1, u=32767.
//     - ov_clr pulse -> ov_sticky=0.
//  6. Stream: 8 back-to-back samples, then en=0 for 3 cycles mid-stream.
//     -> outputs appear in order, none dropped or duplicated, out_valid frozen during the stall.

Source files
------------

// File: rtl/smc_obv_ctrl_pipe_if.sv
// rtl/smc_obv_ctrl_pipe_if.sv - sample/handshake bundle for the SMC + observer controller pipe
interface smc_obv_ctrl_pipe_if #(
   parameter int W = 32
);
   logic                en;
   logic                in_valid;
   logic signed [W-1:0] thetad;
   logic signed [W-1:0] dthetad;
   logic signed [W-1:0] ddthetad;
   logic signed [W-1:0] theta;
   logic signed [W-1:0] dtheta;
   logic signed [W-1:0] dp;
   logic                ov_clr;
   logic signed [W-1:0] u;
   logic                out_valid;
   logic                u_sat;
   logic                ov_sticky;

   modport master (
      output en, in_valid, thetad, dthetad, ddthetad, theta, dtheta, dp, ov_clr,
      input  u, out_valid, u_sat, ov_sticky
   );

   modport slave (
      input  en, in_valid, thetad, dthetad, ddthetad, theta, dtheta, dp, ov_clr,
      output u, out_valid, u_sat, ov_sticky
   );
endinterface

// File: rtl/smc_obv_ctrl_pipe.sv
// rtl/smc_obv_ctrl_pipe.sv - 6-stage saturating sliding-mode controller with observer feedforward
module smc_obv_ctrl_pipe #(
   parameter int W        = 32,
   parameter int GW       = 9,
   parameter int C        = 10,
   parameter int K        = 10,
   parameter int B        = 25,
   parameter int XITE     = 1000,
   parameter int JM       = 7,
   parameter int JD       = 7,
   parameter int BOUNDARY = 0,
   parameter int PHI_SH   = 4,
   parameter int U_MAX    = 32767
) (
   input  logic              clk,
   input  logic              rst_n,
   smc_obv_ctrl_pipe_if.slave bus
);
   localparam int PW = W + GW + 1;
   localparam logic signed [W-1:0] MAX_V  = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] MIN_V  = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W-1:0] XITE_V = W'(XITE);
   localparam logic signed [W-1:0] UMAX_V = W'(U_MAX);
   localparam logic [GW-1:0]       C_G    = GW'(C);
   localparam logic [GW-1:0]       K_G    = GW'(K);
   localparam logic [GW-1:0]       B_G    = GW'(B);

   // Both helpers return {overflow, saturated value}.
   function automatic logic [W:0] add_sat(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b,
                                          input logic                sub);
      logic [W:0] x;
      x = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
      if (x[W] != x[W-1]) return {1'b1, x[W] ? MIN_V : MAX_V};
      return {1'b0, x[W-1:0]};
   endfunction

   function automatic logic [W:0] mul_sat(input logic signed [W-1:0] a,
                                          input logic [GW-1:0]       g);
      logic signed [PW-1:0] p;
      p = $signed({{(GW+1){a[W-1]}}, a}) * $signed({{(W+1){1'b0}}, g});
      if (!((&p[PW-1:W-1]) || !(|p[PW-1:W-1]))) return {1'b1, p[PW-1] ? MIN_V : MAX_V};
      return {1'b0, p[W-1:0]};
   endfunction

   logic                r_s1_v, r_s2_v, r_s3_v, r_s4_v, r_s5_v;
   logic signed [W-1:0] r_s1_e, r_s1_de, r_s1_bd, r_s1_dp, r_s1_dd;
   logic signed [W-1:0] r_s2_ce, r_s2_cde, r_s2_obve, r_s2_de, r_s2_dd;
   logic signed [W-1:0] r_s3_s, r_s3_u1, r_s3_obv, r_s3_sw;
   logic signed [W-1:0] r_s4_ks, r_s4_u2, r_s4_u1;
   logic signed [W-1:0] r_s5_u3, r_s5_ks;
   logic signed [W-1:0] r_u;
   logic                r_out_valid, r_u_sat, r_ov_sticky;

   logic signed [W-1:0] w_e, w_de, w_bd, w_ce, w_cde, w_obve, w_s, w_u1, w_obv, w_phi, w_sw;
   logic signed [W-1:0] w_ks, w_u2, w_u3, w_ut, w_ush, w_u;
   logic                w_ov_e, w_ov_de, w_ov_bd, w_ov_ce, w_ov_cde, w_ov_obve;
   logic                w_ov_s, w_ov_u1, w_ov_ks, w_ov_u2, w_ov_u3, w_ov_ut;
   logic                w_clamp, w_ev;

   assign {w_ov_e,    w_e}    = add_sat(bus.thetad, bus.theta, 1'b1);
   assign {w_ov_de,   w_de}   = add_sat(bus.dthetad, bus.dtheta, 1'b1);
   assign {w_ov_bd,   w_bd}   = mul_sat(bus.dtheta, B_G);
   assign {w_ov_ce,   w_ce}   = mul_sat(r_s1_e, C_G);
   assign {w_ov_cde,  w_cde}  = mul_sat(r_s1_de, C_G);
   assign {w_ov_obve, w_obve} = add_sat(r_s1_bd, r_s1_dp, 1'b1);
   assign {w_ov_s,    w_s}    = add_sat(r_s2_ce, r_s2_de, 1'b0);
   assign {w_ov_u1,   w_u1}   = add_sat(r_s2_cde, r_s2_dd, 1'b0);
   assign {w_ov_ks,   w_ks}   = mul_sat(r_s3_s, K_G);
   assign {w_ov_u2,   w_u2}   = add_sat(r_s3_obv, r_s3_sw, 1'b0);
   assign {w_ov_u3,   w_u3}   = add_sat(r_s4_u1, r_s4_u2, 1'b0);
   assign {w_ov_ut,   w_ut}   = add_sat(r_s5_u3, r_s5_ks, 1'b0);

   assign w_obv = r_s2_obve >>> JM;
   assign w_phi = w_s >>> PHI_SH;
   assign w_ush = w_ut >>> JD;

   always_comb begin
      w_sw = XITE_V;
      if (BOUNDARY == 0) begin
         w_sw = w_s[W-1] ? -XITE_V : XITE_V;
      end else if (w_phi > XITE_V) begin
         w_sw = XITE_V;
      end else if (w_phi < -XITE_V) begin
         w_sw = -XITE_V;
      end else begin
         w_sw = w_phi;
      end
   end

   always_comb begin
      w_u     = w_ush;
      w_clamp = 1'b0;
      if (w_ush > UMAX_V) begin
         w_u     = UMAX_V;
         w_clamp = 1'b1;
      end else if (w_ush < -UMAX_V) begin
         w_u     = -UMAX_V;
         w_clamp = 1'b1;
      end
   end

   // Saturation only counts when the stage that produced it carries a valid sample.
   assign w_ev = bus.en & ((bus.in_valid & (w_ov_e | w_ov_de | w_ov_bd)) |
                           (r_s1_v & (w_ov_ce | w_ov_cde | w_ov_obve)) |
                           (r_s2_v & (w_ov_s | w_ov_u1)) |
                           (r_s3_v & (w_ov_ks | w_ov_u2)) |
                           (r_s4_v & w_ov_u3) |
                           (r_s5_v & w_ov_ut));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_v <= 1'b0; r_s2_v <= 1'b0; r_s3_v <= 1'b0; r_s4_v <= 1'b0; r_s5_v <= 1'b0;
         r_s1_e <= '0; r_s1_de <= '0; r_s1_bd <= '0; r_s1_dp <= '0; r_s1_dd <= '0;
         r_s2_ce <= '0; r_s2_cde <= '0; r_s2_obve <= '0; r_s2_de <= '0; r_s2_dd <= '0;
         r_s3_s <= '0; r_s3_u1 <= '0; r_s3_obv <= '0; r_s3_sw <= '0;
         r_s4_ks <= '0; r_s4_u2 <= '0; r_s4_u1 <= '0;
         r_s5_u3 <= '0; r_s5_ks <= '0;
         r_u <= '0; r_out_valid <= 1'b0; r_u_sat <= 1'b0;
      end else if (bus.en) begin
         r_s1_v <= bus.in_valid; r_s1_e <= w_e; r_s1_de <= w_de; r_s1_bd <= w_bd;
         r_s1_dp <= bus.dp; r_s1_dd <= bus.ddthetad;
         r_s2_v <= r_s1_v; r_s2_ce <= w_ce; r_s2_cde <= w_cde; r_s2_obve <= w_obve;
         r_s2_de <= r_s1_de; r_s2_dd <= r_s1_dd;
         r_s3_v <= r_s2_v; r_s3_s <= w_s; r_s3_u1 <= w_u1; r_s3_obv <= w_obv; r_s3_sw <= w_sw;
         r_s4_v <= r_s3_v; r_s4_ks <= w_ks; r_s4_u2 <= w_u2; r_s4_u1 <= r_s3_u1;
         r_s5_v <= r_s4_v; r_s5_u3 <= w_u3; r_s5_ks <= r_s4_ks;
         r_out_valid <= r_s5_v;
         if (r_s5_v) begin
            r_u     <= w_u;
            r_u_sat <= w_clamp;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ov_sticky <= 1'b0;
      end else if (w_ev) begin
         r_ov_sticky <= 1'b1;
      end else if (bus.ov_clr) begin
         r_ov_sticky <= 1'b0;
      end
   end

   assign bus.u         = r_u;
   assign bus.out_valid = r_out_valid;
   assign bus.u_sat     = r_u_sat;
   assign bus.ov_sticky = r_ov_sticky;
endmodule

// File: tb/tb_smc_obv_ctrl_pipe.sv
// tb/tb_smc_obv_ctrl_pipe.sv - directed vector bench for smc_obv_ctrl_pipe (sign and boundary-layer variants)
module tb_smc_obv_ctrl_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   smc_obv_ctrl_pipe_if #(.W(32)) bus0 ();
   smc_obv_ctrl_pipe_if #(.W(32)) bus1 ();

   smc_obv_ctrl_pipe #(.BOUNDARY(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   smc_obv_ctrl_pipe #(.BOUNDARY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   typedef struct {
      bit                 bnd;
      logic signed [31:0] thetad, dthetad, ddthetad, theta, dtheta, dp;
      int                 exp_u;
      bit                 exp_sat;
      bit                 exp_ov;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_in(input logic signed [31:0] t, dt, ddt, th, dth, d);
      bus0.thetad = t;  bus0.dthetad = dt; bus0.ddthetad = ddt;
      bus0.theta = th;  bus0.dtheta = dth; bus0.dp = d;
      bus1.thetad = t;  bus1.dthetad = dt; bus1.ddthetad = ddt;
      bus1.theta = th;  bus1.dtheta = dth; bus1.dp = d;
   endtask

   task automatic set_ctl(input logic e, input logic iv, input logic clr);
      bus0.en = e; bus0.in_valid = iv; bus0.ov_clr = clr;
      bus1.en = e; bus1.in_valid = iv; bus1.ov_clr = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint model_u(input longint t);
      longint ut;
      ut = 100 * t + ((t >= 0) ? 1000 : -1000);
      return ut >>> 7;
   endfunction

   task automatic apply_vec(input int idx);
      vec_t v;
      int   cnt;
      logic ovd;
      v = vecs[idx];
      set_ctl(1'b1, 1'b0, 1'b1);
      tick();
      set_in(v.thetad, v.dthetad, v.ddthetad, v.theta, v.dtheta, v.dp);
      set_ctl(1'b1, 1'b1, 1'b0);
      tick();
      set_ctl(1'b1, 1'b0, 1'b0);
      cnt = 1;
      ovd = v.bnd ? bus1.out_valid : bus0.out_valid;
      while (!ovd && cnt < 20) begin
         tick();
         cnt++;
         ovd = v.bnd ? bus1.out_valid : bus0.out_valid;
      end
      check($sformatf("vec%0d_latency", idx), cnt, 6);
      check($sformatf("vec%0d_u", idx), v.bnd ? bus1.u : bus0.u, v.exp_u);
      check($sformatf("vec%0d_u_sat", idx), v.bnd ? bus1.u_sat : bus0.u_sat, v.exp_sat);
      check($sformatf("vec%0d_ov", idx), v.bnd ? bus1.ov_sticky : bus0.ov_sticky, v.exp_ov);
   endtask

   initial begin
      longint outs[$];
      longint prev_u;
      logic   prev_ov;
      int     k_in;
      int     nval;

      vecs[0]  = '{0, 1000, 0, 0, 0, 0, 0, 789, 0, 0};
      vecs[1]  = '{0, -1000, 0, 0, 0, 0, 0, -790, 0, 0};
      vecs[2]  = '{0, 0, 128, 0, 0, 128, 0, 8, 0, 0};
      vecs[3]  = '{1, 1000, 0, 0, 0, 0, 0, 786, 0, 0};
      vecs[4]  = '{0, 1048576, 0, 0, 0, 0, 0, 32767, 1, 0};
      vecs[5]  = '{0, 32'sh7FFF0000, 0, 0, -32'sh7FFF0000, 0, 0, 32767, 1, 1};
      vecs[6]  = '{0, 0, 0, 1280, 0, 0, 0, 17, 0, 0};
      vecs[7]  = '{0, 0, 0, 0, 500, 0, 0, -399, 0, 0};
      vecs[8]  = '{0, -1048576, 0, 0, 0, 0, 0, -32767, 1, 0};
      vecs[9]  = '{0, 0, 0, 0, 0, 0, 12800, 7, 0, 0};
      vecs[10] = '{1, 2000, 0, 0, 0, 0, 0, 1570, 0, 0};
      vecs[11] = '{1, -100, 0, 0, 0, 0, 0, -79, 0, 0};

      // Reset overrides en and in_valid.
      set_in(1000, 0, 0, 0, 0, 0);
      set_ctl(1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_u", bus0.u, 0);
         check("rst_out_valid", bus0.out_valid, 0);
         check("rst_ov_sticky", bus0.ov_sticky, 0);
      end
      set_ctl(1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) apply_vec(i);

      // Saturating sample: sticky flag, output hold while idle, then clear.
      apply_vec(5);
      for (int i = 0; i < 3; i++) tick();
      check("hold_out_valid", bus0.out_valid, 0);
      check("hold_u", bus0.u, 32767);
      check("hold_ov_sticky", bus0.ov_sticky, 1);
      set_ctl(1'b1, 1'b0, 1'b1);
      tick();
      set_ctl(1'b1, 1'b0, 1'b0);
      check("ov_clr", bus0.ov_sticky, 0);

      // Back-to-back stream with a 3-cycle en stall once outputs are flowing.
      k_in = 0;
      prev_u = bus0.u;
      prev_ov = bus0.out_valid;
      for (int cyc = 0; cyc < 40 && outs.size() < 8; cyc++) begin
         set_in(32'(-3000 + 1000 * k_in), 0, 0, 0, 0, 0);
         if (cyc >= 7 && cyc <= 9) set_ctl(1'b0, 1'b0, 1'b0);
         else set_ctl(1'b1, k_in < 8, 1'b0);
         tick();
         if (bus0.en) begin
            if (bus0.in_valid) k_in++;
            if (bus0.out_valid) outs.push_back(longint'(bus0.u));
         end else begin
            check("stall_out_valid", bus0.out_valid, prev_ov);
            check("stall_u", bus0.u, prev_u);
         end
         prev_ov = bus0.out_valid;
         prev_u = bus0.u;
      end
      set_ctl(1'b1, 1'b0, 1'b0);
      check("stream_count", outs.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("stream_u%0d", i), (i < outs.size()) ? outs[i] : 64'sd999999,
               model_u(-3000 + 1000 * i));
      end
      tick();
      check("stream_drained", bus0.out_valid, 0);

      // Reset mid-flight discards the in-flight sample.
      set_in(1000, 0, 0, 0, 0, 0);
      set_ctl(1'b1, 1'b1, 1'b0);
      tick();
      set_ctl(1'b1, 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      nval = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus0.out_valid) nval++;
      end
      check("flush_no_valid", nval, 0);
      check("flush_u", bus0.u, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
